// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save resolve stage.
// Holds the FSM state enum, chunk-count helper and config checks.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // ceil((width + 1) / chunk): the resolved value is width+1 bits
    // wide before the final carry-out.
    function automatic int nchunk(input int width, input int chunk);
        return (width + chunk) / chunk;
    endfunction

    function automatic bit cfg_ok(input int width, input int chunk);
        return (width >= 2) && (chunk >= 1) && (chunk <= width + 1);
    endfunction

endpackage

// File: rtl/csa_resolve_adder_if.sv
// Handshake bundle for csa_resolve_adder: upstream pair + result.
// slave = the adder, master = the surrounding producer/consumer.
interface csa_resolve_adder_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] out_data;

    modport slave (
        input  in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/csa_chunk_add.sv
// Combinational CHUNK-bit ripple adder used once per resolve cycle.
// Ports: a, b, cin in; s (CHUNK bits), cout out.
module csa_chunk_add #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);
    logic [CHUNK:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[CHUNK];
    end
endmodule

// File: rtl/csa_resolve_adder.sv
// Resolves a CSA (sum, carry) pair to sum + 2*carry, CHUNK bits/clk.
// Ports: clk, rst_n, bus (slave: in/out handshakes), busy.
module csa_resolve_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CHUNK = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    csa_resolve_adder_if.slave  bus,
    output logic                busy
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int PW     = NCHUNK * CHUNK;
    localparam int OW     = WIDTH + 2;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $fatal(1, "csa_resolve_adder: bad WIDTH/CHUNK");
    end

    state_t           state_q;
    state_t           state_d;
    logic [PW-1:0]    opa_q;
    logic [PW-1:0]    opb_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    acc_d;
    logic [IW-1:0]    idx_q;
    logic             cin_q;
    logic [OW-1:0]    data_q;
    logic [OW-1:0]    res_c;
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] s_c;
    logic             cout_c;
    logic             last_c;

    assign a_c    = opa_q[int'(idx_q)*CHUNK +: CHUNK];
    assign b_c    = opb_q[int'(idx_q)*CHUNK +: CHUNK];
    assign last_c = (idx_q == IW'(NCHUNK - 1));

    csa_chunk_add #(
        .CHUNK (CHUNK)
    ) u_add (
        .a    (a_c),
        .b    (b_c),
        .cin  (cin_q),
        .s    (s_c),
        .cout (cout_c)
    );

    // Final carry-out sits just above the accumulator; it only
    // survives the truncation when PW < WIDTH+2.
    always_comb begin
        acc_d = acc_q;
        acc_d[int'(idx_q)*CHUNK +: CHUNK] = s_c;
        res_c = OW'({cout_c, acc_d});
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = BUSY;
            BUSY:    if (last_c) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q  <= '0;
            opb_q  <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
            cin_q  <= 1'b0;
            data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        opa_q <= PW'(bus.in_sum);
                        opb_q <= PW'({bus.in_carry, 1'b0});
                        acc_q <= '0;
                        idx_q <= '0;
                        cin_q <= 1'b0;
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    cin_q <= cout_c;
                    idx_q <= idx_q + 1'b1;
                    if (last_c) data_q <= res_c;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = data_q;
    assign busy          = (state_q == BUSY);
endmodule
